// File: rtl/lcd_pixel_feeder.sv
// Command-driven pixel source for the ILI9341 byte driver: a FWFT command FIFO
// drained by a busy-observed request/hold handshake FSM.
module lcd_pixel_feeder #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 17
) (
  input  logic                          clk_16MHz,
  input  logic                          resetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [15:0]                   cmd_color,
  input  logic [CNT_W-1:0]              cmd_count,
  input  logic                          flush,
  input  logic                          lcd_busy,
  output logic [15:0]                   pix_data,
  output logic                          pix_clk,
  output logic                          reset_cursor,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 2 + 16 + CNT_W;
  localparam logic [1:0] OP_PIXEL = 2'd0;
  localparam logic [1:0] OP_FILL  = 2'd1;
  localparam logic [1:0] OP_HOME  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_REQ, S_HOLD} state_t;

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [15:0]      color_q, color_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [15:0]      pix_data_q, pix_data_d;
  logic             pix_clk_q, pix_clk_d;
  logic             reset_cursor_q, reset_cursor_d;

  logic             full, empty, push, pop;
  logic [ENT_W-1:0] head;
  logic [1:0]       head_op;
  logic [15:0]      head_color;
  logic [CNT_W-1:0] head_count;

  assign full       = (level_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty      = (level_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign head_op    = head[ENT_W-1 -: 2];
  assign head_color = head[CNT_W +: 16];
  assign head_count = head[CNT_W-1:0];

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign pop       = (state_q == S_IDLE) && !empty && !flush;
  assign cmd_ready = !full || pop;
  assign push      = cmd_valid && cmd_ready && !flush;

  always_ff @(posedge clk_16MHz) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_color, cmd_count};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    color_d        = color_q;
    remain_d       = remain_q;
    pix_data_d     = pix_data_q;
    pix_clk_d      = pix_clk_q;
    reset_cursor_d = reset_cursor_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          op_d    = head_op;
          color_d = head_color;
          case (head_op)
            OP_PIXEL: begin remain_d = CNT_W'(1); state_d = S_ISSUE; end
            OP_FILL: begin
              if (head_count != '0) begin
                remain_d = head_count;
                state_d  = S_ISSUE;
              end
            end
            OP_HOME: begin remain_d = '0; state_d = S_ISSUE; end
            default: ;
          endcase
        end
      end
      S_ISSUE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (!lcd_busy) begin
          if (op_q == OP_HOME) begin
            reset_cursor_d = 1'b1;
          end else begin
            pix_data_d = color_q;
            pix_clk_d  = 1'b1;
            remain_d   = remain_q - CNT_W'(1);
          end
          state_d = S_REQ;
        end
      end
      // The driver may be blind for a cycle, so the level holds until busy is seen.
      S_REQ: begin
        if (lcd_busy) begin
          pix_clk_d      = 1'b0;
          reset_cursor_d = 1'b0;
          state_d        = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!lcd_busy) state_d = (remain_q != '0 && !flush) ? S_ISSUE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) remain_d = '0;
  end

  always_ff @(posedge clk_16MHz or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      state_q        <= S_IDLE;
      op_q           <= '0;
      color_q        <= '0;
      remain_q       <= '0;
      pix_data_q     <= '0;
      pix_clk_q      <= 1'b0;
      reset_cursor_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      state_q        <= state_d;
      op_q           <= op_d;
      color_q        <= color_d;
      remain_q       <= remain_d;
      pix_data_q     <= pix_data_d;
      pix_clk_q      <= pix_clk_d;
      reset_cursor_q <= reset_cursor_d;
    end
  end

  assign pix_data     = pix_data_q;
  assign pix_clk      = pix_clk_q;
  assign reset_cursor = reset_cursor_q;
  assign fifo_level   = level_q;
  assign idle         = empty && (state_q == S_IDLE);

endmodule

// File: tb/tb_lcd_pixel_feeder.sv
// Scoreboard bench for lcd_pixel_feeder: a behavioural byte-driver model accepts
// requests and checks each against tokens expanded from the pushed commands.
`timescale 1ns/1ps
module tb_lcd_pixel_feeder;

  localparam int CNT_W = 17;

  logic              clk_16MHz = 1'b0;
  logic              resetn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = '0;
  logic [15:0]       cmd_color = '0;
  logic [CNT_W-1:0]  cmd_count = '0;
  logic              flush = 1'b0;
  logic              lcd_busy = 1'b0;
  logic [15:0]       pix_data;
  logic              pix_clk;
  logic              reset_cursor;
  logic [4:0]        fifo_level;
  logic              idle;

  lcd_pixel_feeder #(.FIFO_DEPTH(16), .CNT_W(CNT_W)) dut (
    .clk_16MHz(clk_16MHz), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_color(cmd_color), .cmd_count(cmd_count), .flush(flush),
    .lcd_busy(lcd_busy), .pix_data(pix_data), .pix_clk(pix_clk), .reset_cursor(reset_cursor),
    .fifo_level(fifo_level), .idle(idle)
  );

  initial forever #31 clk_16MHz = ~clk_16MHz;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected driver-side transactions: {is_home, colour}
  logic [16:0] exp_q[$];

  int          busy_cnt = 0;
  bit          blind = 1'b0;
  bit          ignore_mode = 1'b0;
  bit          force_busy = 1'b0;
  int          acc_count = 0;
  logic [15:0] held_data = '0;
  bit          held_is_pixel = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  task automatic model_push(input logic [1:0] op, input logic [15:0] color,
                            input logic [CNT_W-1:0] count);
    case (op)
      2'd0: exp_q.push_back({1'b0, color});
      2'd1: for (int i = 0; i < int'(count); i++) exp_q.push_back({1'b0, color});
      2'd2: exp_q.push_back({1'b1, 16'h0000});
      default: ;
    endcase
  endtask

  // Called just after a negedge; returns on a negedge once the push is accepted.
  task automatic apply_stimulus(input logic [1:0] op, input logic [15:0] color,
                                input logic [CNT_W-1:0] count, input int budget);
    bit accepted = 1'b0;
    cmd_op = op; cmd_color = color; cmd_count = count; cmd_valid = 1'b1;
    for (int t = 0; t < budget; t++) begin
      #1;
      if (cmd_ready) begin
        model_push(op, color, count);
        accepted = 1'b1;
      end
      @(negedge clk_16MHz);
      if (accepted) break;
    end
    cmd_valid = 1'b0;
    if (!accepted) begin
      n_checks++;
      $display("[TB] FAIL push_timeout: got cmd_ready=0 for %0d cycles required 1", budget);
    end
  endtask

  task automatic wait_drain(input int budget);
    int quiet = 0;
    for (int t = 0; t < budget && quiet < 4; t++) begin
      @(negedge clk_16MHz);
      #1;
      if (idle && !lcd_busy && !pix_clk && !reset_cursor) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) begin
      n_checks++;
      $display("[TB] FAIL drain_timeout: got busy feeder after %0d cycles required idle", budget);
    end
    check_output("queue_empty", exp_q.size(), 0);
    check_output("level_drained", fifo_level, 0);
  endtask

  task automatic wait_accepts(input int target, input int budget);
    int t = 0;
    while (acc_count < target && t < budget) begin
      @(negedge clk_16MHz);
      #1;
      t++;
    end
    if (acc_count < target) begin
      n_checks++;
      $display("[TB] FAIL accept_timeout: got %0d accepts required %0d", acc_count, target);
    end
  endtask

  // Byte-driver model and scoreboard monitor
  always @(negedge clk_16MHz) begin
    logic [16:0] tok;
    logic [16:0] e;
    if (!resetn) begin
      lcd_busy = 1'b0;
      busy_cnt = 0;
      blind    = 1'b0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        if (held_is_pixel) check_output("pix_data_held", pix_data, held_data);
        lcd_busy = force_busy;
        blind    = ignore_mode;
      end
    end else if (force_busy) begin
      lcd_busy = 1'b1;
    end else begin
      lcd_busy = 1'b0;
      if (pix_clk || reset_cursor) begin
        if (blind) begin
          blind = 1'b0;
        end else begin
          check_output("req_exclusive", {31'd0, pix_clk & reset_cursor}, 0);
          tok = reset_cursor ? {1'b1, 16'h0000} : {1'b0, pix_data};
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL unexpected_req: got token 0x%0h required none", tok);
          end else begin
            e = exp_q.pop_front();
            check_output("req_token", tok, e);
          end
          acc_count++;
          held_data     = pix_data;
          held_is_pixel = !reset_cursor;
          lcd_busy      = 1'b1;
          busy_cnt      = $urandom_range(4, 2);
        end
      end
    end
  end

  initial begin
    #(62 * 90000);
    $display("[TB] FAIL watchdog: got no finish required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    $display("[TB] start");
    repeat (3) @(negedge clk_16MHz);
    check_output("rst_pix_data", pix_data, 0);
    check_output("rst_pix_clk", pix_clk, 0);
    check_output("rst_reset_cursor", reset_cursor, 0);
    check_output("rst_fifo_level", fifo_level, 0);
    check_output("rst_cmd_ready", cmd_ready, 1);
    check_output("rst_idle", idle, 1);
    resetn = 1'b1;
    repeat (2) @(negedge clk_16MHz);

    // Single pixel
    apply_stimulus(2'd0, 16'hF800, '0, 50);
    wait_drain(200);
    check_output("pixel_idle", idle, 1);
    check_output("pixel_data_kept", pix_data, 16'hF800);

    // Short fill, then a zero-length fill
    base = acc_count;
    apply_stimulus(2'd1, 16'h07E0, 17'd5, 50);
    wait_drain(300);
    check_output("fill5_count", acc_count - base, 5);
    base = acc_count;
    apply_stimulus(2'd1, 16'h1234, 17'd0, 50);
    wait_drain(100);
    check_output("fill0_count", acc_count - base, 0);

    // Driver blind cycle after every pair
    ignore_mode = 1'b1;
    base = acc_count;
    apply_stimulus(2'd1, 16'hBEEF, 17'd300, 50);
    wait_drain(8000);
    check_output("blind_fill_count", acc_count - base, 300);
    ignore_mode = 1'b0;

    // Fill FIFO behind a busy driver
    force_busy = 1'b1;
    repeat (2) @(negedge clk_16MHz);
    for (int i = 0; i < 17; i++) apply_stimulus(2'd0, 16'($urandom), '0, 20);
    #1;
    check_output("full_level", fifo_level, 16);
    check_output("full_cmd_ready", cmd_ready, 0);
    check_output("no_req_while_busy", {31'd0, pix_clk | reset_cursor}, 0);
    force_busy = 1'b0;
    apply_stimulus(2'd0, 16'hC0DE, '0, 200);
    #1;
    check_output("push_pop_full_level", fifo_level, 16);
    wait_drain(2000);

    // HOME then PIXEL ordering
    apply_stimulus(2'd2, 16'hFFFF, 17'd9, 50);
    apply_stimulus(2'd0, 16'h001F, '0, 50);
    wait_drain(200);
    check_output("home_pixel_data", pix_data, 16'h001F);

    // Flush in the middle of a long fill
    base = acc_count;
    apply_stimulus(2'd1, 16'h5555, 17'd1000, 50);
    apply_stimulus(2'd0, 16'hAAAA, '0, 50);
    wait_accepts(base + 11, 2000);
    flush = 1'b1;
    exp_q.delete();
    @(negedge clk_16MHz);
    flush = 1'b0;
    wait_drain(300);
    check_output("flush_count", acc_count - base, 11);

    // Randomised command mix
    for (int i = 0; i < 40; i++) begin
      ignore_mode = 1'($urandom_range(1, 0));
      apply_stimulus(2'($urandom_range(3, 0)), 16'($urandom),
                     CNT_W'($urandom_range(6, 0)), 500);
      repeat ($urandom_range(3, 0)) @(negedge clk_16MHz);
    end
    wait_drain(5000);
    ignore_mode = 1'b0;

    // Asynchronous reset mid-fill
    base = acc_count;
    apply_stimulus(2'd1, 16'h1357, 17'd200, 50);
    wait_accepts(base + 3, 500);
    resetn = 1'b0;
    #1;
    check_output("midrst_pix_clk", pix_clk, 0);
    check_output("midrst_pix_data", pix_data, 0);
    check_output("midrst_reset_cursor", reset_cursor, 0);
    check_output("midrst_level", fifo_level, 0);
    check_output("midrst_idle", idle, 1);
    exp_q.delete();
    repeat (3) @(negedge clk_16MHz);
    resetn = 1'b1;
    @(negedge clk_16MHz);
    apply_stimulus(2'd0, 16'h5A5A, '0, 50);
    wait_drain(200);
    check_output("post_rst_pixel", pix_data, 16'h5A5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
